// File: rtl/sync_fifo_flex_pkg.sv
// Shared types and helpers for the flexible single-clock FIFO.
package fifo_pkg;

    typedef enum logic [0:0] {
        RD_REG  = 1'b0,
        RD_FWFT = 1'b1
    } rd_mode_e;

    // Explicit wrap so non-power-of-two depths never index past the last entry.
    function automatic int unsigned ptr_inc(int unsigned ptr, int unsigned depth);
        return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/sync_fifo_flex_if.sv
// Producer/consumer bundle for sync_fifo_flex; the FIFO takes the slave side.
interface sync_fifo_flex_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16
) ();

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic              underflow;

    modport master (
        output wr_en, wr_data, rd_en,
        input  rd_data, rd_valid, full, empty, almost_full, almost_empty, count,
               overflow, underflow
    );

    modport slave (
        input  wr_en, wr_data, rd_en,
        output rd_data, rd_valid, full, empty, almost_full, almost_empty, count,
               overflow, underflow
    );

endinterface

// File: rtl/sync_fifo_flex_mem.sv
// FIFO storage: synchronous write, asynchronous read, no reset.
module sync_fifo_mem #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [PTR_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [PTR_W-1:0]  rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_flex.sv
// Parametrised single-clock FIFO with threshold flags, sticky error flags and
// a selectable registered or first-word-fall-through read path.
module sync_fifo_flex
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned AF_LEVEL = DEPTH - 2,
    parameter int unsigned AE_LEVEL = 2,
    parameter int unsigned FWFT     = 0
) (
    input logic             clk,
    input logic             rst_n,
    sync_fifo_flex_if.slave bus
);

    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
    localparam rd_mode_e    RD_MODE = (FWFT != 0) ? RD_FWFT : RD_REG;

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              full, empty;
    logic              wr_acc, rd_acc;
    logic [DATA_W-1:0] mem_rd_data;

    assign full  = (32'(count_q) == DEPTH);
    assign empty = (count_q == '0);

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a paired write.
    assign rd_acc = bus.rd_en && !empty;
    assign wr_acc = bus.wr_en && (!full || rd_acc);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q | (bus.wr_en & full & ~bus.rd_en);
        underflow_d = underflow_q | (bus.rd_en & empty);
        if (wr_acc) begin
            wr_ptr_d = PTR_W'(ptr_inc(32'(wr_ptr_q), DEPTH));
        end
        if (rd_acc) begin
            rd_ptr_d = PTR_W'(ptr_inc(32'(rd_ptr_q), DEPTH));
        end
        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    sync_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr_q),
        .wr_data (bus.wr_data),
        .rd_addr (rd_ptr_q),
        .rd_data (mem_rd_data)
    );

    if (RD_MODE == RD_FWFT) begin : g_fwft
        // Memory is not cleared, so mask the head while empty to keep rd_data at 0 after reset.
        assign bus.rd_data  = empty ? '0 : mem_rd_data;
        assign bus.rd_valid = !empty;
    end else begin : g_reg
        logic [DATA_W-1:0] rd_data_q;
        logic              rd_valid_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                if (rd_acc) begin
                    rd_data_q <= mem_rd_data;
                end
                rd_valid_q <= rd_acc;
            end
        end

        assign bus.rd_data  = rd_data_q;
        assign bus.rd_valid = rd_valid_q;
    end

    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (32'(count_q) >= AF_LEVEL);
    assign bus.almost_empty = (32'(count_q) <= AE_LEVEL);
    assign bus.count        = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Directed bench for sync_fifo_flex: registered depth-16, registered depth-5 and FWFT depth-4.
module tb_sync_fifo_flex;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_miss;

    sync_fifo_flex_if #(.DATA_W(8), .DEPTH(16)) bus16 ();
    sync_fifo_flex_if #(.DATA_W(8), .DEPTH(5))  bus5 ();
    sync_fifo_flex_if #(.DATA_W(8), .DEPTH(4))  busf ();

    sync_fifo_flex #(.DATA_W(8), .DEPTH(16), .FWFT(0)) u_dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus16.slave)
    );

    sync_fifo_flex #(.DATA_W(8), .DEPTH(5), .FWFT(0)) u_dut5 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus5.slave)
    );

    sync_fifo_flex #(.DATA_W(8), .DEPTH(4), .FWFT(1)) u_dutf (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (busf.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;
        rst_n  = 1'b0;
        {bus16.wr_en, bus16.rd_en, bus16.wr_data} = '0;
        {bus5.wr_en, bus5.rd_en, bus5.wr_data}    = '0;
        {busf.wr_en, busf.rd_en, busf.wr_data}    = '0;
        #23;
        rst_n = 1'b1;
        tick();

        // Reset state
        check_eq("rst_empty", 32'(bus16.empty), 32'd1);
        check_eq("rst_aempty", 32'(bus16.almost_empty), 32'd1);
        check_eq("rst_full", 32'(bus16.full), 32'd0);
        check_eq("rst_afull", 32'(bus16.almost_full), 32'd0);
        check_eq("rst_count", 32'(bus16.count), 32'd0);
        check_eq("rst_rd_valid", 32'(bus16.rd_valid), 32'd0);
        check_eq("rst_rd_data", 32'(bus16.rd_data), 32'd0);
        check_eq("rst_flags", 32'({bus16.overflow, bus16.underflow}), 32'd0);

        // Fill depth-16 with 0x00..0x0F
        for (int i = 0; i < 16; i++) begin
            bus16.wr_en   = 1'b1;
            bus16.wr_data = 8'(i);
            tick();
            check_eq($sformatf("fill_count_%0d", i), 32'(bus16.count), 32'(i + 1));
            check_eq($sformatf("fill_afull_%0d", i), 32'(bus16.almost_full), 32'(i + 1 >= 14));
            check_eq($sformatf("fill_full_%0d", i), 32'(bus16.full), 32'(i == 15));
            check_eq($sformatf("fill_aempty_%0d", i), 32'(bus16.almost_empty), 32'(i + 1 <= 2));
        end
        bus16.wr_data = 8'hEE;
        tick();
        check_eq("ovf_set", 32'(bus16.overflow), 32'd1);
        check_eq("ovf_count", 32'(bus16.count), 32'd16);

        // Full: simultaneous read and write keeps count, pops 0x00
        bus16.wr_data = 8'hAA;
        bus16.rd_en   = 1'b1;
        tick();
        bus16.wr_en = 1'b0;
        check_eq("rw_full_count", 32'(bus16.count), 32'd16);
        check_eq("rw_full_data", 32'(bus16.rd_data), 32'h00);
        check_eq("rw_full_valid", 32'(bus16.rd_valid), 32'd1);

        // Drain: 0x01..0x0F then 0xAA
        for (int i = 1; i <= 16; i++) begin
            tick();
            check_eq($sformatf("drain_data_%0d", i), 32'(bus16.rd_data),
                     (i < 16) ? 32'(i) : 32'hAA);
            check_eq($sformatf("drain_valid_%0d", i), 32'(bus16.rd_valid), 32'd1);
            check_eq($sformatf("drain_count_%0d", i), 32'(bus16.count), 32'(16 - i));
        end
        bus16.rd_en = 1'b0;
        tick();
        check_eq("drain_empty", 32'(bus16.empty), 32'd1);
        check_eq("idle_valid", 32'(bus16.rd_valid), 32'd0);
        check_eq("idle_hold", 32'(bus16.rd_data), 32'hAA);
        check_eq("no_udf_yet", 32'(bus16.underflow), 32'd0);
        bus16.rd_en = 1'b1;
        tick();
        bus16.rd_en = 1'b0;
        check_eq("udf_set", 32'(bus16.underflow), 32'd1);
        check_eq("udf_valid", 32'(bus16.rd_valid), 32'd0);
        check_eq("udf_count", 32'(bus16.count), 32'd0);

        // Depth-5: read+write on empty is write-only and flags underflow
        bus5.wr_en   = 1'b1;
        bus5.rd_en   = 1'b1;
        bus5.wr_data = 8'h40;
        tick();
        bus5.rd_en = 1'b0;
        check_eq("d5_empty_rw_count", 32'(bus5.count), 32'd1);
        check_eq("d5_empty_rw_udf", 32'(bus5.underflow), 32'd1);
        check_eq("d5_empty_rw_valid", 32'(bus5.rd_valid), 32'd0);
        for (int i = 1; i < 4; i++) begin
            bus5.wr_data = 8'(8'h40 + i);
            tick();
        end
        check_eq("d5_count4", 32'(bus5.count), 32'd4);
        check_eq("d5_afull", 32'(bus5.almost_full), 32'd1);
        check_eq("d5_aempty", 32'(bus5.almost_empty), 32'd0);

        // 12 paired write/read: pointers wrap 4->0 several times
        bus5.rd_en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            bus5.wr_data = 8'(8'h44 + i);
            tick();
            check_eq($sformatf("d5_pair_data_%0d", i), 32'(bus5.rd_data), 32'(8'h40 + i));
            check_eq($sformatf("d5_pair_count_%0d", i), 32'(bus5.count), 32'd4);
        end
        bus5.wr_en = 1'b0;
        for (int i = 12; i < 16; i++) begin
            tick();
            check_eq($sformatf("d5_tail_%0d", i), 32'(bus5.rd_data), 32'(8'h40 + i));
        end
        bus5.rd_en = 1'b0;
        tick();
        check_eq("d5_drained", 32'(bus5.empty), 32'd1);
        check_eq("d5_no_ovf", 32'(bus5.overflow), 32'd0);

        // FWFT: head visible without rd_en
        check_eq("fw_rst_valid", 32'(busf.rd_valid), 32'd0);
        check_eq("fw_rst_data", 32'(busf.rd_data), 32'd0);
        busf.wr_en   = 1'b1;
        busf.wr_data = 8'h5A;
        tick();
        busf.wr_en = 1'b0;
        check_eq("fw_valid", 32'(busf.rd_valid), 32'd1);
        check_eq("fw_data", 32'(busf.rd_data), 32'h5A);
        tick();
        check_eq("fw_hold", 32'(busf.rd_data), 32'h5A);
        busf.rd_en = 1'b1;
        tick();
        busf.rd_en = 1'b0;
        check_eq("fw_pop_empty", 32'(busf.empty), 32'd1);
        check_eq("fw_pop_valid", 32'(busf.rd_valid), 32'd0);
        busf.wr_en   = 1'b1;
        busf.wr_data = 8'h11;
        tick();
        busf.wr_data = 8'h22;
        tick();
        busf.wr_en = 1'b0;
        check_eq("fw_head1", 32'(busf.rd_data), 32'h11);
        busf.rd_en = 1'b1;
        tick();
        busf.rd_en = 1'b0;
        check_eq("fw_head2", 32'(busf.rd_data), 32'h22);
        check_eq("fw_count1", 32'(busf.count), 32'd1);

        // Async reset mid-burst at count=7
        bus16.wr_en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            bus16.wr_data = 8'(8'h60 + i);
            tick();
        end
        check_eq("pre_rst_count", 32'(bus16.count), 32'd7);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_count", 32'(bus16.count), 32'd0);
        check_eq("arst_empty", 32'(bus16.empty), 32'd1);
        check_eq("arst_aempty", 32'(bus16.almost_empty), 32'd1);
        check_eq("arst_full", 32'({bus16.full, bus16.almost_full}), 32'd0);
        check_eq("arst_rd_data", 32'(bus16.rd_data), 32'd0);
        check_eq("arst_rd_valid", 32'(bus16.rd_valid), 32'd0);
        check_eq("arst_sticky", 32'({bus16.overflow, bus16.underflow}), 32'd0);
        check_eq("arst_d5_udf", 32'(bus5.underflow), 32'd0);
        check_eq("arst_fw_valid", 32'(busf.rd_valid), 32'd0);
        bus16.wr_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Normal operation resumes after reset
        bus16.wr_en   = 1'b1;
        bus16.wr_data = 8'h77;
        tick();
        bus16.wr_en = 1'b0;
        bus16.rd_en = 1'b1;
        tick();
        bus16.rd_en = 1'b0;
        check_eq("post_rst_data", 32'(bus16.rd_data), 32'h77);
        check_eq("post_rst_empty", 32'(bus16.empty), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
